// File: rtl/div_n_if.sv
// Start/ready handshake bundle between the calculator front end and the div_n divider.
interface div_n_if #(
   parameter int unsigned N = 8
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] div;
   logic [N-1:0] mod;
   logic         rdy;
   logic         div_err;

   modport master (output start, a, b, input div, mod, rdy, div_err);
   modport slave  (input start, a, b, output div, mod, rdy, div_err);
endinterface

// File: rtl/div_n.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional macro DIV_N_BUSY_EN adds a registered busy output (high in CALC/DONE).
module div_n #(
   parameter int unsigned N = 8
) (
   input  logic    clk,
   input  logic    reset,
   div_n_if.slave  bus
`ifdef DIV_N_BUSY_EN
   ,
   output logic    busy
`endif
);
   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state;
   logic [N-1:0]  quot;
   logic [N-1:0]  rem;
   logic [N-1:0]  bq;
   logic [CW-1:0] cnt;
   logic          zdiv;
   logic [N-1:0]  div_q;
   logic [N-1:0]  mod_q;
   logic          rdy_q;
   logic          err_q;
   logic          busy_q;

   logic [N:0]    trial;
   logic          fits;
   logic [N-1:0]  rem_nx;
   logic [N-1:0]  quot_nx;

   // One restoring step: N+1 bit trial remainder so the compare never overflows.
   always_comb begin
      trial   = {rem, quot[N-1]};
      fits    = (trial >= {1'b0, bq});
      rem_nx  = trial[N-1:0];
      if (fits) rem_nx = N'(trial - {1'b0, bq});
      quot_nx = {quot[N-2:0], fits};
   end

   // A zero divisor runs a single dummy step so rdy lands one edge after acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         quot   <= '0;
         rem    <= '0;
         bq     <= '0;
         cnt    <= '0;
         zdiv   <= 1'b0;
         div_q  <= '0;
         mod_q  <= '0;
         rdy_q  <= 1'b0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bq     <= bus.b;
                  quot   <= bus.a;
                  rem    <= '0;
                  zdiv   <= (bus.b == '0);
                  cnt    <= (bus.b == '0) ? CW'(1) : CW'(N);
                  busy_q <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               quot <= quot_nx;
               rem  <= rem_nx;
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  rdy_q <= 1'b1;
                  state <= DONE;
                  if (zdiv) begin
                     div_q <= '1;
                     mod_q <= quot;
                     err_q <= 1'b1;
                  end else begin
                     div_q <= quot_nx;
                     mod_q <= rem_nx;
                     err_q <= 1'b0;
                  end
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.div     = div_q;
   assign bus.mod     = mod_q;
   assign bus.rdy     = rdy_q;
   assign bus.div_err = err_q;

`ifdef DIV_N_BUSY_EN
   assign busy = busy_q;
`else
   logic unused_busy;
   assign unused_busy = busy_q;
`endif
endmodule

// File: tb/tb_div_n.sv
// Scoreboard bench for div_n: expected quotient/remainder/latency queued at drive time.
module tb_div_n;
   localparam int unsigned N = 8;

   typedef struct packed {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         err;
      logic [7:0]   lat;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb[$];
   int   n_cmp;
   int   n_err;
   int   rdy_pulses;

   div_n_if #(.N(N)) bus ();
`ifdef DIV_N_BUSY_EN
   logic busy;
   div_n #(.N(N)) u_dut (.clk(clk), .reset(rst_n), .bus(bus), .busy(busy));
`else
   div_n #(.N(N)) u_dut (.clk(clk), .reset(rst_n), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // rdy is a full-cycle pulse, so each one is seen at exactly one falling edge.
   always @(negedge clk) if (bus.rdy === 1'b1) rdy_pulses++;

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.q = '1; e.r = a; e.err = 1'b1; e.lat = 8'd1;
      end else begin
         e.q = a / b; e.r = a % b; e.err = 1'b0; e.lat = 8'(N);
      end
      return e;
   endfunction

   task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, input int hold, input string tag);
      exp_t e;
      int   cyc;
      int   p0;
      bit   got;
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b;
      sb.push_back(model(a, b));
      p0 = rdy_pulses; cyc = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc >= hold) bus.start = 1'b0;
         if (bus.rdy === 1'b1) got = 1;
      end
      bus.start = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (!got) begin
         n_err++; $display("FAIL %s timeout: no rdy within 40 cycles (need rdy after %0d edges)", tag, e.lat);
      end else begin
         if (8'(cyc - 1) !== e.lat) begin n_err++; $display("FAIL %s latency: got %0d need %0d", tag, cyc - 1, e.lat); end
         n_cmp++;
         if (bus.div !== e.q) begin n_err++; $display("FAIL %s div: got %h need %h", tag, bus.div, e.q); end
         n_cmp++;
         if (bus.mod !== e.r) begin n_err++; $display("FAIL %s mod: got %h need %h", tag, bus.mod, e.r); end
         n_cmp++;
         if (bus.div_err !== e.err) begin n_err++; $display("FAIL %s div_err: got %b need %b", tag, bus.div_err, e.err); end
         @(posedge clk); #1;
         n_cmp++;
         if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL %s rdy_width: got %b need 0", tag, bus.rdy); end
      end
      repeat (4) @(posedge clk);
      n_cmp++;
      if (rdy_pulses - p0 !== 1) begin n_err++; $display("FAIL %s pulses: got %0d need 1", tag, rdy_pulses - p0); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
      #23;
      n_cmp++;
      if ({bus.div, bus.mod, bus.rdy, bus.div_err} !== '0) begin
         n_err++; $display("FAIL reset_outputs: div=%h mod=%h rdy=%b err=%b need all 0", bus.div, bus.mod, bus.rdy, bus.div_err);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      n_cmp++;
      if (rdy_pulses !== 0) begin n_err++; $display("FAIL idle_no_rdy: got %0d pulses need 0", rdy_pulses); end
      n_cmp++;
      if ({bus.div, bus.mod, bus.div_err} !== '0) begin
         n_err++; $display("FAIL idle_outputs: div=%h mod=%h err=%b need 0", bus.div, bus.mod, bus.div_err);
      end
   endtask

   task automatic test_basic();
      do_div(8'h08, 8'h02, 2, "d8_2_hold2");
      do_div(8'hFF, 8'h07, 1, "dFF_7");
      do_div(8'h05, 8'h09, 1, "d5_9");
   endtask

   task automatic test_div_zero();
      do_div(8'h2A, 8'h00, 1, "dzero");
      do_div(8'd100, 8'd10, 1, "after_dzero");
   endtask

   task automatic test_ignore_restart();
      exp_t e;
      int   cyc;
      int   p0;
      bit   got;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd3;
      sb.push_back(model(8'd200, 8'd3));
      p0 = rdy_pulses; cyc = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         cyc++;
         case (cyc)
            1: bus.start = 1'b0;
            3: begin bus.start = 1'b1; bus.a = 8'd5; bus.b = 8'd1; end
            4: begin bus.start = 1'b0; bus.a = 8'hAA; bus.b = 8'h11; end
            default: ;
         endcase
         if (bus.rdy === 1'b1) got = 1;
      end
      e = sb.pop_front();
      n_cmp++;
      if (!got || bus.div !== e.q || bus.mod !== e.r || bus.div_err !== e.err) begin
         n_err++; $display("FAIL restart_result: rdy=%b div=%0d mod=%0d err=%b need div=%0d mod=%0d err=%b",
                           got, bus.div, bus.mod, bus.div_err, e.q, e.r, e.err);
      end
      repeat (14) @(posedge clk);
      n_cmp++;
      if (rdy_pulses - p0 !== 1) begin n_err++; $display("FAIL restart_not_queued: got %0d pulses need 1", rdy_pulses - p0); end
   endtask

   task automatic test_reset_mid();
      int p0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'd77; bus.b = 8'd5;
      p0 = rdy_pulses;
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.div, bus.mod, bus.rdy, bus.div_err} !== '0) begin
         n_err++; $display("FAIL midreset_outputs: div=%h mod=%h rdy=%b err=%b need all 0", bus.div, bus.mod, bus.rdy, bus.div_err);
      end
      repeat (12) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (12) @(posedge clk);
      n_cmp++;
      if (rdy_pulses !== p0) begin n_err++; $display("FAIL midreset_no_rdy: got %0d pulses need 0", rdy_pulses - p0); end
      do_div(8'd9, 8'd4, 1, "after_midreset");
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      for (int k = 0; k < 6; k++) begin
         ra = N'($urandom_range(0, 255));
         rb = (k == 3) ? '0 : N'($urandom_range(1, 255));
         do_div(ra, rb, 1 + (k % 3), "random");
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; rdy_pulses = 0;
      test_reset();
      test_basic();
      test_div_zero();
      test_ignore_restart();
      test_reset_mid();
      test_back_to_back();
      n_cmp++;
      if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: %0d left need 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
